// File: rtl/wb_fabric_mailbox.sv
// Wishbone-slave mailbox between the management SoC and the fabric: TX FIFO (WB->fabric),
// RX FIFO (fabric->WB), status and sticky flags. Define MAILBOX_IRQ_EN to build IRQ_EN/IRQ_STAT and user_irq.
module wb_fabric_mailbox #(
    parameter int          DATA_W   = 32,
    parameter int          DEPTH    = 8,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic [DATA_W-1:0] fab_tx_data,
    output logic              fab_tx_valid,
    input  logic              fab_tx_ready,
    input  logic [DATA_W-1:0] fab_rx_data,
    input  logic              fab_rx_valid,
    output logic              fab_rx_ready,
    output logic              user_irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [2:0] OFF_TXDATA   = 3'd0;
    localparam logic [2:0] OFF_RXDATA   = 3'd1;
    localparam logic [2:0] OFF_STATUS   = 3'd2;
    localparam logic [2:0] OFF_IRQ_EN   = 3'd3;
    localparam logic [2:0] OFF_IRQ_STAT = 3'd4;

    logic              ack_q;
    logic [31:0]       dat_q;
    logic              hit, req;
    logic [2:0]        off;
    logic [31:0]       rdata;

    logic [DATA_W-1:0] tx_mem [DEPTH];
    logic [AW-1:0]     tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [CW-1:0]     tx_count_q, tx_count_d;
    logic              tx_empty, tx_full, tx_push_req, tx_push, tx_pop;

    logic [DATA_W-1:0] rx_mem [DEPTH];
    logic [AW-1:0]     rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [CW-1:0]     rx_count_q, rx_count_d;
    logic              rx_empty, rx_full, rx_rd, rx_push, rx_pop;
    logic [DATA_W-1:0] rx_head;

    // Bits that only matter in some builds or widths.
    logic unused_inputs;
    assign unused_inputs = ^{wbs_sel_i, wbs_dat_i, wbs_adr_i[1:0]};

    assign off = wbs_adr_i[4:2];
    assign hit = (wbs_adr_i & ~32'h1F) == BASE_ADR;
    assign req = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

    // Full/empty always come from the registered count, never from same-edge activity.
    assign tx_empty    = tx_count_q == '0;
    assign tx_full     = tx_count_q == FULL_CNT;
    assign tx_push_req = req & wbs_we_i & (off == OFF_TXDATA);
    assign tx_push     = tx_push_req & ~tx_full;
    assign tx_pop      = ~tx_empty & fab_tx_ready;

    assign rx_empty = rx_count_q == '0;
    assign rx_full  = rx_count_q == FULL_CNT;
    assign rx_rd    = req & ~wbs_we_i & (off == OFF_RXDATA);
    assign rx_push  = fab_rx_valid & ~rx_full;
    assign rx_pop   = rx_rd & ~rx_empty;
    assign rx_head  = rx_empty ? '0 : rx_mem[rx_rptr_q];

    assign fab_tx_valid = ~tx_empty;
    assign fab_tx_data  = tx_empty ? '0 : tx_mem[tx_rptr_q];
    assign fab_rx_ready = ~rx_full;

    always_comb begin
        tx_wptr_d  = tx_wptr_q;
        tx_rptr_d  = tx_rptr_q;
        rx_wptr_d  = rx_wptr_q;
        rx_rptr_d  = rx_rptr_q;
        if (tx_push) tx_wptr_d = tx_wptr_q + AW'(1);
        if (tx_pop)  tx_rptr_d = tx_rptr_q + AW'(1);
        if (rx_push) rx_wptr_d = rx_wptr_q + AW'(1);
        if (rx_pop)  rx_rptr_d = rx_rptr_q + AW'(1);
        tx_count_d = tx_count_q + CW'(tx_push) - CW'(tx_pop);
        rx_count_d = rx_count_q + CW'(rx_push) - CW'(rx_pop);
    end

`ifdef MAILBOX_IRQ_EN
    logic [3:0] irq_en_q, irq_en_d, irq_stat_q, irq_stat_d, irq_evt, irq_clr;
    logic       irq_q;
    logic       tx_ovf, tx_drain, rx_udf, reg_wr0;

    assign tx_ovf   = tx_push_req & tx_full;
    assign tx_drain = ~tx_empty & (tx_count_d == '0);
    assign rx_udf   = rx_rd & rx_empty;
    assign reg_wr0  = req & wbs_we_i & wbs_sel_i[0];
    assign irq_evt  = {rx_udf, tx_ovf, tx_drain, rx_push};
    assign irq_clr  = (reg_wr0 && off == OFF_IRQ_STAT) ? wbs_dat_i[3:0] : 4'h0;

    // Set after clear so an event coinciding with its W1C keeps the flag.
    always_comb begin
        irq_en_d   = irq_en_q;
        if (reg_wr0 && off == OFF_IRQ_EN) irq_en_d = wbs_dat_i[3:0];
        irq_stat_d = (irq_stat_q & ~irq_clr) | irq_evt;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_en_q   <= 4'h0;
            irq_stat_q <= 4'h0;
            irq_q      <= 1'b0;
        end else begin
            irq_en_q   <= irq_en_d;
            irq_stat_q <= irq_stat_d;
            irq_q      <= |(irq_stat_q & irq_en_q);
        end
    end

    assign user_irq = irq_q;
`else
    assign user_irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (off)
            OFF_RXDATA:   rdata = 32'(rx_head);
            OFF_STATUS:   rdata = {8'h00, 8'(rx_count_q), 8'(tx_count_q),
                                   4'h0, rx_full, rx_empty, tx_full, tx_empty};
`ifdef MAILBOX_IRQ_EN
            OFF_IRQ_EN:   rdata = {28'h0, irq_en_q};
            OFF_IRQ_STAT: rdata = {28'h0, irq_stat_q};
`endif
            default:      rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_count_q <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_count_q <= '0;
        end else begin
            ack_q      <= req;
            dat_q      <= (req & ~wbs_we_i) ? rdata : '0;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_count_q <= tx_count_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_count_q <= rx_count_d;
        end
    end

    // Storage needs no reset: content is only visible through the reset-cleared counts.
    always_ff @(posedge wb_clk_i) begin
        if (tx_push) tx_mem[tx_wptr_q] <= wbs_dat_i[DATA_W-1:0];
        if (rx_push) rx_mem[rx_wptr_q] <= fab_rx_data;
    end

endmodule

// File: tb/tb_wb_fabric_mailbox.sv
// Self-checking bench for wb_fabric_mailbox: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_wb_fabric_mailbox;
    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 8;
    localparam logic [31:0] BASE   = 32'h3000_0000;
`ifdef MAILBOX_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic clk, rst_n;
    logic cyc, stb, we;
    logic [3:0] sel;
    logic [31:0] dat_i, adr;
    logic tx_ready, rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic ack;
    logic [31:0] dat_o;
    logic [DATA_W-1:0] tx_data;
    logic tx_valid, rx_ready, irq;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model state
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    logic [3:0]  m_stat, m_en;
    logic        m_irq, m_ack;
    logic [31:0] m_dat;

    wb_fabric_mailbox #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADR(BASE)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .fab_tx_data(tx_data), .fab_tx_valid(tx_valid), .fab_tx_ready(tx_ready),
        .fab_rx_data(rx_data), .fab_rx_valid(rx_valid), .fab_rx_ready(rx_ready),
        .user_irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        m_stat = 4'h0; m_en = 4'h0; m_irq = 1'b0; m_ack = 1'b0; m_dat = 32'h0;
    endtask

    // Predicts the effect of the next rising edge from the current inputs.
    task automatic model_edge();
        logic req, rd, nirq;
        logic [2:0] o;
        logic [3:0] ev, clr;
        logic [31:0] rv;
        int tw, rw;
        o   = adr[4:2];
        req = cyc && stb && ((adr & ~32'h1F) == BASE) && !m_ack;
        rd  = req && !we;
        tw  = tx_q.size();
        rw  = rx_q.size();
        ev = 4'h0; clr = 4'h0; rv = 32'h0;
        if (rd) begin
            case (o)
                3'd1: if (rw > 0) rv = rx_q[0]; else ev[3] = 1'b1;
                3'd2: begin
                    rv[0] = (tw == 0); rv[1] = (tw == DEPTH);
                    rv[2] = (rw == 0); rv[3] = (rw == DEPTH);
                    rv[15:8] = 8'(tw); rv[23:16] = 8'(rw);
                end
                3'd3: rv = IRQ_ON ? {28'h0, m_en} : 32'h0;
                3'd4: rv = IRQ_ON ? {28'h0, m_stat} : 32'h0;
                default: rv = 32'h0;
            endcase
        end
        nirq = IRQ_ON && ((m_stat & m_en) != 4'h0);
        if (tx_ready && tw > 0) void'(tx_q.pop_front());
        if (req && we && o == 3'd0) begin
            if (tw == DEPTH) ev[2] = 1'b1;
            else tx_q.push_back(32'(dat_i[DATA_W-1:0]));
        end
        if (tw > 0 && tx_q.size() == 0) ev[1] = 1'b1;
        if (rd && o == 3'd1 && rw > 0) void'(rx_q.pop_front());
        if (rx_valid && rw < DEPTH) begin
            rx_q.push_back(32'(rx_data));
            ev[0] = 1'b1;
        end
        if (req && we && sel[0] && o == 3'd3 && IRQ_ON) m_en = dat_i[3:0];
        if (req && we && sel[0] && o == 3'd4) clr = dat_i[3:0];
        m_stat = (m_stat & ~clr) | ev;
        m_ack  = req;
        m_dat  = rd ? rv : 32'h0;
        m_irq  = nirq;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cyc = 0; stb = 0; we = 0; sel = 4'h0; dat_i = 32'h0; adr = 32'h0;
        tx_ready = 0; rx_valid = 0; rx_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One strobe cycle plus one idle cycle; returns ack/data seen right after the ack edge.
    task automatic wb_access(input logic w, input logic [2:0] o, input logic [31:0] d,
                             input logic [3:0] s, output logic a, output logic [31:0] r);
        cyc = 1; stb = 1; we = w; adr = BASE + {27'h0, o, 2'b00}; dat_i = d; sel = s;
        cycle();
        a = ack; r = dat_o;
        cyc = 0; stb = 0; we = 0;
        cycle();
    endtask

    task automatic test_reset();
        logic a; logic [31:0] r;
        do_reset();
        n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got %b want 0", ack); end
        n_vec++; if (dat_o !== 32'h0) begin n_err++; $display("FAIL reset_dat got %h want 0", dat_o); end
        n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        n_vec++; if (tx_data !== '0) begin n_err++; $display("FAIL reset_tx_data got %h want 0", tx_data); end
        n_vec++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_rx_ready got %b want 1", rx_ready); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", irq); end
        wb_access(1'b0, 3'd2, 32'h0, 4'hF, a, r);
        n_vec++; if (a !== 1'b1 || r !== 32'h5) begin n_err++; $display("FAIL reset_status got ack %b %h want 1 00000005", a, r); end
    endtask

    task automatic test_reset_mid_write();
        logic a; logic [31:0] r;
        do_reset();
        for (int i = 0; i < 3; i++) wb_access(1'b1, 3'd0, 32'h10 + i, 4'hF, a, r);
        cyc = 1; stb = 1; we = 1; adr = BASE; dat_i = 32'h99; sel = 4'hF;
        cycle();
        n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL midrst_ack_before got %b want 1", ack); end
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL midrst_ack_drop got %b want 0", ack); end
        n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL midrst_tx_valid got %b want 0", tx_valid); end
        model_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        wb_access(1'b0, 3'd2, 32'h0, 4'hF, a, r);
        n_vec++; if (r !== 32'h0000_0005) begin n_err++; $display("FAIL midrst_status got %h want 00000005", r); end
        n_vec++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL midrst_rx_ready got %b want 1", rx_ready); end
    endtask

    task automatic test_tx_basic();
        logic a; logic [31:0] r;
        do_reset();
        wb_access(1'b1, 3'd0, 32'hA5, 4'hF, a, r);
        n_vec++; if (a !== 1'b1) begin n_err++; $display("FAIL tx_ack got %b want 1", a); end
        n_vec++; if (tx_valid !== 1'b1 || tx_data !== 32'hA5) begin n_err++; $display("FAIL tx_head got %b %h want 1 a5", tx_valid, tx_data); end
        tx_ready = 1;
        cycle();
        tx_ready = 0;
        n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_popped got %b want 0", tx_valid); end
        wb_access(1'b0, 3'd4, 32'h0, 4'hF, a, r);
        n_vec++; if (r !== (IRQ_ON ? 32'h2 : 32'h0)) begin n_err++; $display("FAIL tx_drain_flag got %h want %h", r, IRQ_ON ? 32'h2 : 32'h0); end
    endtask

    task automatic test_tx_overflow();
        logic a; logic [31:0] r;
        do_reset();
        for (int i = 0; i <= DEPTH; i++) wb_access(1'b1, 3'd0, i, 4'hF, a, r);
        wb_access(1'b0, 3'd2, 32'h0, 4'hF, a, r);
        n_vec++; if (r !== 32'h0000_0806) begin n_err++; $display("FAIL ovf_status got %h want 00000806", r); end
        wb_access(1'b0, 3'd4, 32'h0, 4'hF, a, r);
        n_vec++; if (r !== (IRQ_ON ? 32'h4 : 32'h0)) begin n_err++; $display("FAIL ovf_flag got %h want %h", r, IRQ_ON ? 32'h4 : 32'h0); end
        tx_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            n_vec++; if (tx_valid !== 1'b1 || tx_data !== DATA_W'(i)) begin n_err++; $display("FAIL ovf_drain[%0d] got %b %h want 1 %h", i, tx_valid, tx_data, i); end
            cycle();
        end
        tx_ready = 0;
        n_vec++; if (tx_valid !== 1'b0 || tx_data !== '0) begin n_err++; $display("FAIL ovf_dropped got %b %h want 0 0", tx_valid, tx_data); end
    endtask

    task automatic test_rx_basic();
        logic a; logic [31:0] r;
        do_reset();
        rx_valid = 1; rx_data = 32'h11; cycle();
        rx_data = 32'h22; cycle();
        rx_valid = 0;
        wb_access(1'b0, 3'd2, 32'h0, 4'hF, a, r);
        n_vec++; if (r !== 32'h0002_0001) begin n_err++; $display("FAIL rx_status2 got %h want 00020001", r); end
        wb_access(1'b0, 3'd1, 32'h0, 4'hF, a, r);
        n_vec++; if (r !== 32'h11) begin n_err++; $display("FAIL rx_pop0 got %h want 11", r); end
        wb_access(1'b0, 3'd1, 32'h0, 4'hF, a, r);
        n_vec++; if (r !== 32'h22) begin n_err++; $display("FAIL rx_pop1 got %h want 22", r); end
        wb_access(1'b0, 3'd1, 32'h0, 4'hF, a, r);
        n_vec++; if (a !== 1'b1 || r !== 32'h0) begin n_err++; $display("FAIL rx_udf_read got %b %h want 1 0", a, r); end
        wb_access(1'b0, 3'd2, 32'h0, 4'hF, a, r);
        n_vec++; if (r !== 32'h0000_0005) begin n_err++; $display("FAIL rx_status0 got %h want 00000005", r); end
        wb_access(1'b0, 3'd4, 32'h0, 4'hF, a, r);
        n_vec++; if (r !== (IRQ_ON ? 32'h9 : 32'h0)) begin n_err++; $display("FAIL rx_flags got %h want %h", r, IRQ_ON ? 32'h9 : 32'h0); end
    endtask

    task automatic test_rx_full_stream();
        logic a; logic [31:0] r;
        logic [31:0] popped[$];
        do_reset();
        rx_valid = 1;
        for (int i = 0; i < DEPTH; i++) begin
            rx_data = 32'hC0 + i;
            cycle();
        end
        rx_data = 32'hEE;
        cycle();
        n_vec++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL rxfull_ready got %b want 0", rx_ready); end
        cyc = 1; stb = 1; we = 0; adr = BASE + 32'h4; sel = 4'hF;
        cycle();
        n_vec++; if (ack !== 1'b1 || dat_o !== 32'hC0) begin n_err++; $display("FAIL rxfull_head got %b %h want 1 c0", ack, dat_o); end
        n_vec++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL rxfull_ready_after got %b want 1", rx_ready); end
        cyc = 0; stb = 0; rx_valid = 0;
        cycle();
        wb_access(1'b0, 3'd2, 32'h0, 4'hF, a, r);
        n_vec++; if (r !== 32'h0007_0001) begin n_err++; $display("FAIL rxfull_status got %h want 00070001", r); end
        tx_ready = 1;
        for (int i = 0; i < 12; i++) begin
            cyc = 1; stb = 1; we = 1; adr = BASE; dat_i = 32'h100 + i;
            if (tx_valid) popped.push_back(32'(tx_data));
            cycle();
            cyc = 0; stb = 0; we = 0;
            if (tx_valid) popped.push_back(32'(tx_data));
            cycle();
        end
        tx_ready = 0;
        n_vec++; if (popped.size() != 12) begin n_err++; $display("FAIL stream_count got %0d want 12", popped.size()); end
        for (int i = 0; i < popped.size() && i < 12; i++) begin
            n_vec++; if (popped[i] !== 32'h100 + i) begin n_err++; $display("FAIL stream_word[%0d] got %h want %h", i, popped[i], 32'h100 + i); end
        end
        wb_access(1'b0, 3'd4, 32'h0, 4'hF, a, r);
        n_vec++; if (r[2] !== 1'b0 || r !== m_dat) begin n_err++; $display("FAIL stream_flags got %h want %h", r, m_dat); end
    endtask

    task automatic test_irq();
        logic a; logic [31:0] r;
        do_reset();
        wb_access(1'b1, 3'd3, 32'h1, 4'h1, a, r);
        rx_valid = 1; rx_data = 32'h33;
        cycle();
        rx_valid = 0;
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_lag got %b want 0", irq); end
        cycle();
        n_vec++; if (irq !== IRQ_ON) begin n_err++; $display("FAIL irq_rise got %b want %b", irq, IRQ_ON); end
        cyc = 1; stb = 1; we = 1; adr = BASE + 32'h10; dat_i = 32'h1; sel = 4'h1;
        rx_valid = 1; rx_data = 32'h44;
        cycle();
        cyc = 0; stb = 0; we = 0; rx_valid = 0;
        cycle();
        wb_access(1'b0, 3'd4, 32'h0, 4'hF, a, r);
        n_vec++; if (r !== (IRQ_ON ? 32'h1 : 32'h0)) begin n_err++; $display("FAIL irq_set_wins got %h want %h", r, IRQ_ON ? 32'h1 : 32'h0); end
        n_vec++; if (irq !== IRQ_ON) begin n_err++; $display("FAIL irq_held got %b want %b", irq, IRQ_ON); end
        cyc = 1; stb = 1; we = 1; adr = BASE + 32'h10; dat_i = 32'h1; sel = 4'h1;
        cycle();
        cyc = 0; stb = 0; we = 0;
        n_vec++; if (irq !== m_irq) begin n_err++; $display("FAIL irq_w1c_edge got %b want %b", irq, m_irq); end
        cycle();
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_cleared got %b want 0", irq); end
        wb_access(1'b1, 3'd3, 32'hF, 4'hE, a, r);
        wb_access(1'b0, 3'd3, 32'h0, 4'hF, a, r);
        n_vec++; if (r !== (IRQ_ON ? 32'h1 : 32'h0)) begin n_err++; $display("FAIL irq_en_lane got %h want %h", r, IRQ_ON ? 32'h1 : 32'h0); end
    endtask

    task automatic test_back_to_back();
        logic a; logic [31:0] r;
        do_reset();
        cyc = 1; stb = 1; we = 1; adr = BASE; sel = 4'hF;
        for (int i = 0; i < 6; i++) begin
            dat_i = 32'h200 + i;
            cycle();
            n_vec++; if (ack !== ((i % 2) == 0)) begin n_err++; $display("FAIL b2b_ack[%0d] got %b want %b", i, ack, (i % 2) == 0); end
        end
        adr = BASE + 32'h20;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL miss_ack[%0d] got %b want 0", i, ack); end
        end
        cyc = 0; stb = 0; we = 0;
        cycle();
        wb_access(1'b0, 3'd2, 32'h0, 4'hF, a, r);
        n_vec++; if (r !== 32'h0000_0304) begin n_err++; $display("FAIL b2b_status got %h want 00000304", r); end
        n_vec++; if (tx_data !== 32'h200) begin n_err++; $display("FAIL b2b_head got %h want 200", tx_data); end
    endtask

    task automatic test_random();
        logic [2:0] o;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            o   = 3'($urandom_range(0, 7));
            cyc = ($urandom_range(0, 9) < 7);
            stb = ($urandom_range(0, 9) < 6);
            we  = $urandom_range(0, 1);
            sel = 4'($urandom);
            dat_i = $urandom;
            if (o == 3'd3 || o == 3'd4) dat_i[3:0] = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0:       adr = BASE + 32'h20 * $urandom_range(1, 4) + {27'h0, o, 2'b00};
                1:       adr = (BASE ^ 32'h1000_0000) | {27'h0, o, 2'b00};
                default: adr = BASE | {27'h0, o, 2'($urandom_range(0, 3))};
            endcase
            tx_ready = ($urandom_range(0, 9) < 4);
            rx_valid = ($urandom_range(0, 9) < 4);
            rx_data  = DATA_W'($urandom);
            cycle();
            n_vec++; if (ack !== m_ack) begin n_err++; $display("FAIL rnd_ack[%0d] got %b want %b", n, ack, m_ack); end
            if (m_ack) begin
                n_vec++; if (dat_o !== m_dat) begin n_err++; $display("FAIL rnd_dat[%0d] got %h want %h", n, dat_o, m_dat); end
            end
            n_vec++; if (tx_valid !== (tx_q.size() > 0)) begin n_err++; $display("FAIL rnd_tx_valid[%0d] got %b want %b", n, tx_valid, tx_q.size() > 0); end
            n_vec++; if (32'(tx_data) !== (tx_q.size() > 0 ? tx_q[0] : 32'h0)) begin n_err++; $display("FAIL rnd_tx_data[%0d] got %h", n, tx_data); end
            n_vec++; if (rx_ready !== (rx_q.size() < DEPTH)) begin n_err++; $display("FAIL rnd_rx_ready[%0d] got %b want %b", n, rx_ready, rx_q.size() < DEPTH); end
            n_vec++; if (irq !== m_irq) begin n_err++; $display("FAIL rnd_irq[%0d] got %b want %b", n, irq, m_irq); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        test_reset();
        test_reset_mid_write();
        test_tx_basic();
        test_tx_overflow();
        test_rx_basic();
        test_rx_full_stream();
        test_irq();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
